seq_alu: RTL
============

Name: seq_alu

Overview:
Parametrised, registered ALU that succeeds the datapath's combinational 4-op ALU.
- Widens the op set to eight operations, with operand width set by a parameter.
- Adds a start/busy/done handshake and a full N/Z/C/V status flag set.
- Supports an optional multi-cycle iterative multiply.
- Sits between the register-file read ports and the writeback mux; the controller FSM launches an op with start and waits for done.

Parameters:
WIDTH, 16, operand and result width in bits (>= 4, power of two).
SHW, $clog2(WIDTH), shift-amount field width taken from Bin[SHW-1:0] (derived; do not override).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
start  input  1  launch request; sampled only when busy=0
op  input  3  operation select, captured with start
Ain  input  WIDTH  operand A, captured with start
Bin  input  WIDTH  operand B, captured with start
out  output  WIDTH  registered result, held until the next done
Z  output  1  result == 0
N  output  1  out[WIDTH-1]
C  output  1  carry out on ADD; borrow (Ain < Bin unsigned) on SUB; last bit shifted out on SHL; 0 otherwise
V  output  1  signed overflow on ADD/SUB; 0 otherwise
busy  output  1  high while a multi-cycle op is in progress
done  output  1  one-cycle pulse when out and the flags update

Behaviour:
- Reset: asynchronous, active-high, one clock domain (clk).
  - out=0, Z=1, N=0, C=0, V=0, busy=0, done=0, FSM=IDLE.
  - Reset mid-multiply aborts it; no done is issued.
- Op encoding:
  - 000 ADD: Ain+Bin
  - 001 SUB: Ain-Bin
  - 010 AND: Ain&Bin
  - 011 NOT: ~Bin
  - 100 OR: Ain|Bin
  - 101 XOR: Ain^Bin
  - 110 SHL: Ain << Bin[SHW-1:0]
  - 111 MUL: low WIDTH bits of Ain*Bin (see Optional Feature)
- Arithmetic is modulo 2^WIDTH.
- V on ADD: the operands have equal signs and the result sign differs.
- V on SUB: the operands have different signs and the result sign differs from Ain.
- C on SHL with shift amount 0: C=0.
- FSM states: IDLE, MUL.
  - IDLE, start=1, op!=111 (or MUL disabled): compute, register out/flags at this edge, done=1 for the following cycle, stay IDLE. Latency is 1 cycle; back-to-back starts every cycle are legal.
  - IDLE, start=1, op=111 (MUL enabled): capture operands, clear the accumulator, count=0, busy=1, go to MUL.
  - MUL: one shift-add step per cycle (if multiplier bit 0 is set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1), count++.
  - After WIDTH steps: register out=acc with Z/N (C=V=0), busy=0, done=1, return to IDLE. Total latency from the start edge to done is WIDTH+1 cycles.
- start while busy=1 is ignored; op/Ain/Bin changes during MUL have no effect.
- done is never high in two consecutive cycles from a single MUL.
  - done can be high on consecutive cycles only for back-to-back single-cycle ops.
- Flags always correspond to the current out; they change only together with done.

Optional Feature:
Macro SEQ_ALU_MUL_EN.
- Defined: op 111 performs the multi-cycle iterative multiply described above; the MUL state and its accumulator/counter are present.
- Undefined: the MUL state is absent and busy is tied 0. Op 111 completes in one cycle with out=0, Z=1, N=C=V=0, and done pulses normally.

Test Plan:
- WIDTH=16, reset asserted mid-run, then released → out=0x0000, Z=1, N=C=V=0, busy=0, done=0, all asynchronously, before any clock edge.
- ADD 0x7FFF+0x0001 → out=0x8000, N=1, V=1, C=0, Z=0, done one cycle after start. ADD 0xFFFF+0x0001 → out=0x0000, Z=1, C=1, V=0.
- SUB 0x0003-0x0005 → out=0xFFFE, C=1 (borrow), N=1, V=0. SUB 0x1234-0x1234 → out=0, Z=1, C=0.
- SHL 0x8001 by Bin=0x0001 → out=0x0002, C=1. NOT Bin=0x00FF → out=0xFF00, N=1. Back-to-back AND, OR, XOR starts on consecutive cycles → three consecutive done pulses with correct results.
- SEQ_ALU_MUL_EN defined, MUL 0x0012*0x0034 → busy for 16 cycles, done 17 cycles after start, out=0x03A8. A second start during busy is ignored. MUL 0x0100*0x0100 → out=0x0000, Z=1.
- Reset asserted at cycle 5 of a MUL → busy=0 immediately, no done pulse, out=0; a new ADD 0x0002+0x0003 afterwards → out=0x0005.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered eight-op ALU with start/busy/done handshake
//
// Purpose: parametrised ALU between the register-file read ports and the
// writeback mux. A start in IDLE latches a result plus N/Z/C/V flags and
// pulses done one cycle later. Op 111 is an iterative shift-add multiply
// that takes WIDTH+1 cycles when SEQ_ALU_MUL_EN is defined. Without that
// macro, op 111 completes in one cycle with a zero result.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      launch request, sampled only while busy=0
//   op[2:0]    operation select, captured with start
//   Ain, Bin   operands, captured with start
//   out        registered result, held until the next done
//   Z, N, C, V status flags for out; they update together with done
//   busy       high while a multiply is iterating
//   done       one-cycle pulse when out and the flags update
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [WIDTH-1:0] out_q, out_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             done_q, done_d;

  // Single-cycle datapath. Each result is one bit wider than the operands,
  // so the top bit is the carry, the borrow, or the last bit shifted out.
  logic [WIDTH:0]   sum_w, dif_w, shl_w;
  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c;
  logic             take_single;

  assign sum_w = {1'b0, Ain} + {1'b0, Bin};
  assign dif_w = {1'b0, Ain} - {1'b0, Bin};
  assign shl_w = {1'b0, Ain} << Bin[SHW-1:0];

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = sum_w[WIDTH-1:0];
        c_c   = sum_w[WIDTH];
        v_c   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (sum_w[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = dif_w[WIDTH-1:0];
        c_c   = dif_w[WIDTH];
        v_c   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (dif_w[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND: res_c = Ain & Bin;
      OP_NOT: res_c = ~Bin;
      OP_OR:  res_c = Ain | Bin;
      OP_XOR: res_c = Ain ^ Bin;
      OP_SHL: begin
        // A shift of 0 leaves bit WIDTH clear, so C=0 needs no special case.
        res_c = shl_w[WIDTH-1:0];
        c_c   = shl_w[WIDTH];
      end
      default: res_c = '0;  // MUL: handled by the FSM, or zero when MUL is disabled
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step;

  assign acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign take_single = start && (state_q == S_IDLE) && (op != OP_MUL);
  assign busy        = (state_q == S_MUL);
`else
  assign take_single = start;
  assign busy        = 1'b0;
`endif

  always_comb begin
    out_d  = out_q;
    z_d    = z_q;
    n_d    = n_q;
    c_d    = c_q;
    v_d    = v_q;
    done_d = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif

    if (take_single) begin
      out_d  = res_c;
      z_d    = (res_c == '0);
      n_d    = res_c[WIDTH-1];
      c_d    = c_c;
      v_d    = v_c;
      done_d = 1'b1;
    end

`ifdef SEQ_ALU_MUL_EN
    case (state_q)
      S_IDLE: begin
        if (start && (op == OP_MUL)) begin
          acc_d    = '0;
          mcand_d  = Ain;
          mplier_d = Bin;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // The last step's sum goes straight to out, so done follows
        // the WIDTH-th step without an extra cycle.
        if (cnt_q == CNT_LAST) begin
          out_d   = acc_step;
          z_d     = (acc_step == '0);
          n_d     = acc_step[WIDTH-1];
          c_d     = 1'b0;
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      z_q    <= 1'b1;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      z_q    <= z_d;
      n_q    <= n_d;
      c_q    <= c_d;
      v_q    <= v_d;
      done_q <= done_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign out  = out_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign C    = c_q;
  assign V    = v_q;
  assign done = done_q;

endmodule
